// File: rtl/ascon_serial_io.sv
// Serial front-end for the Ascon core: deserialises key/nonce/AD/data/expected tag SW bits
// per beat, launches one core run, then serialises result and tag back out MSB first.
module ascon_serial_io #(
    parameter int K  = 128,
    parameter int L  = 40,
    parameter int Y  = 80,
    parameter int SW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          decrypt,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [SW-1:0] keyxSI,
    input  logic [SW-1:0] noncexSI,
    input  logic [SW-1:0] adxSI,
    input  logic [SW-1:0] dataxSI,
    input  logic [SW-1:0] tagxSI,
    input  logic          start,
    output logic          busy,
    output logic [K-1:0]  core_key,
    output logic [127:0]  core_nonce,
    output logic [L-1:0]  core_ad,
    output logic [Y-1:0]  core_data,
    output logic          core_decrypt,
    output logic          core_start,
    input  logic          core_done,
    input  logic [Y-1:0]  core_result,
    input  logic [127:0]  core_tag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [SW-1:0] dataxSO,
    output logic [SW-1:0] tagxSO,
    output logic          tag_ok,
    output logic          tag_ok_valid,
    output logic          done
);

    localparam int MAX_KN    = (K > 128) ? K : 128;
    localparam int MAX_LY    = (L > Y) ? L : Y;
    localparam int IN_BITS   = (MAX_KN > MAX_LY) ? MAX_KN : MAX_LY;
    localparam int OUT_BITS  = (Y > 128) ? Y : 128;
    localparam int IN_BEATS  = IN_BITS / SW;
    localparam int OUT_BEATS = OUT_BITS / SW;
    localparam int MAX_BEATS = (IN_BEATS > OUT_BEATS) ? IN_BEATS : OUT_BEATS;
    localparam int CW        = $clog2(MAX_BEATS + 1);

    localparam logic [CW-1:0] K_BEATS  = CW'(K / SW);
    localparam logic [CW-1:0] N_BEATS  = CW'(128 / SW);
    localparam logic [CW-1:0] L_BEATS  = CW'(L / SW);
    localparam logic [CW-1:0] Y_BEATS  = CW'(Y / SW);
    localparam logic [CW-1:0] IN_LAST  = CW'(IN_BEATS - 1);
    localparam logic [CW-1:0] OUT_LAST = CW'(OUT_BEATS - 1);

    if ((K % SW) != 0 || (L % SW) != 0 || (Y % SW) != 0 || (128 % SW) != 0) begin : g_width_check
        $error("ascon_serial_io: K, L, Y and 128 must each be a multiple of SW");
    end

    typedef enum logic [1:0] {S_LOAD, S_ARMED, S_RUN, S_UNLOAD} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       beat_q;
    logic [K-1:0]        key_q;
    logic [127:0]        nonce_q;
    logic [L-1:0]        ad_q;
    logic [Y-1:0]        data_q;
    logic [127:0]        exp_tag_q;
    logic [OUT_BITS-1:0] res_sr_q;
    logic [OUT_BITS-1:0] tag_sr_q;
    logic                in_fire;
    logic                last_in;
    logic                last_out;

    assign in_fire  = in_valid & in_ready;
    assign last_in  = (beat_q == IN_LAST);
    assign last_out = (beat_q == OUT_LAST);

    // Parallel views for the core are the load registers themselves; they only move in LOAD.
    assign core_key   = key_q;
    assign core_nonce = nonce_q;
    assign core_ad    = ad_q;
    assign core_data  = data_q;

    assign dataxSO = res_sr_q[OUT_BITS-1 -: SW];
    assign tagxSO  = tag_sr_q[OUT_BITS-1 -: SW];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_LOAD;
        else      state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && last_in) state_d = S_ARMED;
            end
            S_ARMED:  if (start) state_d = S_RUN;
            S_RUN:    if (core_done) state_d = S_UNLOAD;
            S_UNLOAD: if (out_valid && out_ready && last_out) state_d = S_LOAD;
            default:  state_d = S_LOAD;
        endcase
    end

    // NOTE: registers use <= so every assignment here sees the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_q       <= '0;
            key_q        <= '0;
            nonce_q      <= '0;
            ad_q         <= '0;
            data_q       <= '0;
            exp_tag_q    <= '0;
            res_sr_q     <= '0;
            tag_sr_q     <= '0;
            busy         <= 1'b0;
            core_decrypt <= 1'b0;
            core_start   <= 1'b0;
            out_valid    <= 1'b0;
            tag_ok       <= 1'b0;
            tag_ok_valid <= 1'b0;
            done         <= 1'b0;
        end else begin
            core_start   <= 1'b0;
            tag_ok_valid <= 1'b0;
            done         <= 1'b0;
            case (state_q)
                S_LOAD: if (in_fire) begin
                    beat_q <= last_in ? '0 : beat_q + CW'(1);
                    // Shorter fields stop shifting once their own bit count is reached.
                    if (beat_q < K_BEATS) key_q     <= (key_q << SW) | K'(keyxSI);
                    if (beat_q < N_BEATS) nonce_q   <= (nonce_q << SW) | 128'(noncexSI);
                    if (beat_q < N_BEATS) exp_tag_q <= (exp_tag_q << SW) | 128'(tagxSI);
                    if (beat_q < L_BEATS) ad_q      <= (ad_q << SW) | L'(adxSI);
                    if (beat_q < Y_BEATS) data_q    <= (data_q << SW) | Y'(dataxSI);
                end
                S_ARMED: if (start) begin
                    core_start   <= 1'b1;
                    core_decrypt <= decrypt;
                    busy         <= 1'b1;
                    tag_ok       <= 1'b0;
                end
                S_RUN: if (core_done) begin
                    res_sr_q     <= OUT_BITS'(core_result) << (OUT_BITS - Y);
                    tag_sr_q     <= OUT_BITS'(core_tag) << (OUT_BITS - 128);
                    tag_ok       <= core_decrypt & (core_tag == exp_tag_q);
                    tag_ok_valid <= 1'b1;
                end
                S_UNLOAD: begin
                    // One settling cycle after capture before the first beat is offered.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        res_sr_q <= res_sr_q << SW;
                        tag_sr_q <= tag_sr_q << SW;
                        if (last_out) begin
                            beat_q    <= '0;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            beat_q <= beat_q + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_serial_io.sv
// Randomised self-checking bench for ascon_serial_io: an SW=1 and an SW=8 instance, a toy
// keystream/MAC core standing in for Ascon, and a bit-level model of the serial framing.
module tb_ascon_serial_io;

    localparam logic [127:0] KEY   = 128'h2db083053e848cefa30007336c47a5a1;
    localparam logic [127:0] NONCE = 128'h3f3607dbce3503ba84f5843d623de056;
    localparam logic [39:0]  AD    = 40'h4153434f4e;
    localparam logic [79:0]  CT    = 80'h87a59a2ea49b233259e3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_tests      = 0;
    int n_fail       = 0;
    int n_core_start = 0;
    int n_done       = 0;

    // SW = 1 instance
    logic         decrypt, in_valid, in_ready, key_si, nonce_si, ad_si, data_si, tag_si;
    logic         start, busy, core_decrypt, core_start, core_done;
    logic [127:0] core_key, core_nonce, core_tag;
    logic [39:0]  core_ad;
    logic [79:0]  core_data, core_result;
    logic         out_valid, out_ready, data_so, tag_so, tag_ok, tag_ok_valid, done;

    ascon_serial_io #(.K(128), .L(40), .Y(80), .SW(1)) u_dut (
        .clk(clk), .rst(rst), .decrypt(decrypt), .in_valid(in_valid), .in_ready(in_ready),
        .keyxSI(key_si), .noncexSI(nonce_si), .adxSI(ad_si), .dataxSI(data_si), .tagxSI(tag_si),
        .start(start), .busy(busy), .core_key(core_key), .core_nonce(core_nonce),
        .core_ad(core_ad), .core_data(core_data), .core_decrypt(core_decrypt),
        .core_start(core_start), .core_done(core_done), .core_result(core_result),
        .core_tag(core_tag), .out_valid(out_valid), .out_ready(out_ready),
        .dataxSO(data_so), .tagxSO(tag_so), .tag_ok(tag_ok), .tag_ok_valid(tag_ok_valid),
        .done(done)
    );

    // SW = 8 instance
    logic         decrypt8, in_valid8, in_ready8, start8, busy8, core_decrypt8, core_start8, core_done8;
    logic [7:0]   key8, nonce8, ad8, data8, tag8, data_so8, tag_so8;
    logic [127:0] core_key8, core_nonce8, core_tag8;
    logic [39:0]  core_ad8;
    logic [79:0]  core_data8, core_result8;
    logic         out_valid8, out_ready8, tag_ok8, tag_ok_valid8, done8;

    ascon_serial_io #(.K(128), .L(40), .Y(80), .SW(8)) u_dut8 (
        .clk(clk), .rst(rst), .decrypt(decrypt8), .in_valid(in_valid8), .in_ready(in_ready8),
        .keyxSI(key8), .noncexSI(nonce8), .adxSI(ad8), .dataxSI(data8), .tagxSI(tag8),
        .start(start8), .busy(busy8), .core_key(core_key8), .core_nonce(core_nonce8),
        .core_ad(core_ad8), .core_data(core_data8), .core_decrypt(core_decrypt8),
        .core_start(core_start8), .core_done(core_done8), .core_result(core_result8),
        .core_tag(core_tag8), .out_valid(out_valid8), .out_ready(out_ready8),
        .dataxSO(data_so8), .tagxSO(tag_so8), .tag_ok(tag_ok8), .tag_ok_valid(tag_ok_valid8),
        .done(done8)
    );

    always @(posedge clk) begin
        if (core_start === 1'b1) n_core_start++;
        if (done === 1'b1) n_done++;
    end

    // Toy core: XOR keystream cipher plus a MAC over the ciphertext, identical for both modes.
    function automatic logic [79:0] keystream(input logic [127:0] k, input logic [127:0] n,
                                              input logic [39:0] a);
        return k[127:48] ^ n[79:0] ^ {a, a};
    endfunction

    function automatic logic [127:0] mac(input logic [127:0] k, input logic [127:0] n,
                                         input logic [39:0] a, input logic [79:0] c);
        return {k[63:0], k[127:64]} ^ n ^ {a, 8'h5a, c};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic apply_abort(input string name);
        int done0;
        done0 = n_done;
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || {busy, core_key, core_nonce, core_ad, core_data, core_decrypt,
             core_start, out_valid, data_so, tag_so, tag_ok, tag_ok_valid, done} !== '0) begin
            n_fail++;
            $display("FAIL %s_outputs: in_ready=%b busy=%b out_valid=%b key=%h data=%h", name,
                     in_ready, busy, out_valid, core_key, core_data);
        end
        @(negedge clk);
        rst = 1'b1;
        // A late completion from the abandoned run must not revive the unload.
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++;
        if (n_done != done0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1
            || core_start !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_after: dones=%0d want %0d out_valid=%b busy=%b in_ready=%b", name,
                     n_done - done0, 0, out_valid, busy, in_ready);
        end
    endtask

    // One full transaction on the SW=1 instance; abort_mode 1 = reset in RUN, 2 = mid-UNLOAD.
    task automatic run_txn(input string name, input logic dec, input logic [127:0] k,
                           input logic [127:0] n, input logic [39:0] a, input logic [79:0] d,
                           input logic [127:0] t, input bit throttle, input bit early_done,
                           input int abort_mode);
        logic [79:0]  exp_res, got_res;
        logic [127:0] exp_tag, got_tag, k_sh, n_sh, t_sh;
        logic [39:0]  a_sh;
        logic [79:0]  d_sh;
        logic         exp_ok, v, r, ds, ts, hd, ht, held, zero_tail;
        int           i, guard, starts0, done0;
        exp_res = d ^ keystream(k, n, a);
        exp_tag = mac(k, n, a, dec ? d : exp_res);
        exp_ok  = dec && (exp_tag == t);
        starts0 = n_core_start;
        done0   = n_done;

        i = 0;
        guard = 0;
        while (i < 128 && guard < 4000) begin
            @(negedge clk);
            k_sh = k << i; n_sh = n << i; t_sh = t << i; a_sh = a << i; d_sh = d << i;
            v = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            r = in_ready;
            in_valid = v;
            key_si   = k_sh[127];
            nonce_si = n_sh[127];
            tag_si   = t_sh[127];
            ad_si    = (i < 40) ? a_sh[39] : 1'($urandom);
            data_si  = (i < 80) ? d_sh[79] : 1'($urandom);
            start    = throttle ? 1'($urandom_range(0, 1)) : 1'b0;
            decrypt  = 1'($urandom);
            @(posedge clk);
            if (v && r) i++;
            guard++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        n_tests++;
        if (i != 128 || in_ready !== 1'b0 || busy !== 1'b0 || n_core_start != starts0) begin
            n_fail++;
            $display("FAIL %s_armed: beats=%0d want 128 in_ready=%b busy=%b starts=%0d want 0",
                     name, i, in_ready, busy, n_core_start - starts0);
        end
        n_tests++;
        if ({core_key, core_nonce, core_ad, core_data} !== {k, n, a, d}) begin
            n_fail++;
            $display("FAIL %s_core_fields: key=%h nonce=%h ad=%h data=%h want %h %h %h %h",
                     name, core_key, core_nonce, core_ad, core_data, k, n, a, d);
        end

        if (early_done) begin
            core_done   = 1'b1;
            core_result = '1;
            core_tag    = '1;
            @(negedge clk);
            core_done = 1'b0;
            n_tests++;
            if (out_valid !== 1'b0 || tag_ok_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_armed_done: out_valid=%b tag_ok_valid=%b busy=%b in_ready=%b want 0000",
                         name, out_valid, tag_ok_valid, busy, in_ready);
            end
        end

        repeat ($urandom_range(0, 2)) @(negedge clk);
        decrypt = dec;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        decrypt = ~dec;
        n_tests++;
        if (core_start !== 1'b1 || busy !== 1'b1 || core_decrypt !== dec || tag_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_launch: core_start=%b busy=%b core_decrypt=%b want 1 1 %b",
                     name, core_start, busy, core_decrypt, dec);
        end
        @(negedge clk);
        n_tests++;
        if (core_start !== 1'b0 || n_core_start != starts0 + 1 || core_decrypt !== dec) begin
            n_fail++;
            $display("FAIL %s_start_pulse: core_start=%b pulses=%0d want 0 and 1", name,
                     core_start, n_core_start - starts0);
        end

        if (abort_mode == 1) begin
            apply_abort({name, "_run"});
            return;
        end

        repeat ($urandom_range(0, 4)) @(negedge clk);
        core_result = core_data ^ keystream(core_key, core_nonce, core_ad);
        core_tag    = mac(core_key, core_nonce, core_ad, core_decrypt ? core_data : core_result);
        core_done   = 1'b1;
        @(negedge clk);
        core_done   = 1'b0;
        core_result = 80'(rand128());
        core_tag    = rand128();
        n_tests++;
        if (tag_ok_valid !== 1'b1 || tag_ok !== exp_ok || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_tag_ok: tag_ok_valid=%b tag_ok=%b out_valid=%b want 1 %b 0",
                     name, tag_ok_valid, tag_ok, out_valid, exp_ok);
        end
        @(negedge clk);
        n_tests++;
        if (tag_ok_valid !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_unload_latency: tag_ok_valid=%b out_valid=%b want 0 1", name,
                     tag_ok_valid, out_valid);
        end

        i = 0;
        guard = 0;
        held = 1'b0;
        hd = 1'b0;
        ht = 1'b0;
        zero_tail = 1'b1;
        got_res = '0;
        got_tag = '0;
        while (i < 128 && guard < 4000) begin
            if (abort_mode == 2 && i == 10) begin
                out_ready = 1'b0;
                apply_abort({name, "_unload"});
                return;
            end
            v  = out_valid;
            ds = data_so;
            ts = tag_so;
            if (held) begin
                n_tests++;
                if (ds !== hd || ts !== ht || v !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s_stall_hold: beat %0d data=%b tag=%b valid=%b want %b %b 1",
                             name, i, ds, ts, v, hd, ht);
                end
            end
            r = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = r;
            held = v && !r;
            hd = ds;
            ht = ts;
            @(posedge clk);
            if (v && r) begin
                if (i < 80) got_res = {got_res[78:0], ds};
                else if (ds !== 1'b0) zero_tail = 1'b0;
                got_tag = {got_tag[126:0], ts};
                i++;
            end
            guard++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        n_tests++;
        if (i != 128 || done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1
            || tag_ok !== exp_ok) begin
            n_fail++;
            $display("FAIL %s_finish: beats=%0d done=%b busy=%b out_valid=%b in_ready=%b tag_ok=%b want 128 1 0 0 1 %b",
                     name, i, done, busy, out_valid, in_ready, tag_ok, exp_ok);
        end
        n_tests++;
        if (got_res !== exp_res || !zero_tail) begin
            n_fail++;
            $display("FAIL %s_result: got %h zero_tail=%b want %h", name, got_res, zero_tail, exp_res);
        end
        n_tests++;
        if (got_tag !== exp_tag) begin
            n_fail++;
            $display("FAIL %s_tag: got %h want %h", name, got_tag, exp_tag);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || n_done != done0 + 1) begin
            n_fail++;
            $display("FAIL %s_done_pulse: done=%b pulses=%0d want 0 and 1", name, done, n_done - done0);
        end
    endtask

    task automatic test_reset();
        {decrypt, in_valid, key_si, nonce_si, ad_si, data_si, tag_si, start, core_done, out_ready} = '0;
        core_result = '0;
        core_tag    = '0;
        {decrypt8, in_valid8, start8, core_done8, out_ready8} = '0;
        {key8, nonce8, ad8, data8, tag8} = '0;
        core_result8 = '0;
        core_tag8    = '0;
        rst = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || {busy, core_key, core_nonce, core_ad, core_data, core_decrypt,
             core_start, out_valid, data_so, tag_so, tag_ok, tag_ok_valid, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_sw1: in_ready=%b busy=%b out_valid=%b done=%b", in_ready, busy, out_valid, done);
        end
        n_tests++;
        if (in_ready8 !== 1'b1 || {busy8, core_key8, core_nonce8, core_ad8, core_data8, core_decrypt8,
             core_start8, out_valid8, data_so8, tag_so8, tag_ok8, tag_ok_valid8, done8} !== '0) begin
            n_fail++;
            $display("FAIL reset_sw8: in_ready=%b busy=%b out_valid=%b done=%b", in_ready8, busy8, out_valid8, done8);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_encrypt();
        run_txn("enc_vec", 1'b0, KEY, NONCE, AD, CT ^ keystream(KEY, NONCE, AD), rand128(), 0, 0, 0);
    endtask

    task automatic test_decrypt();
        logic [127:0] good_tag;
        good_tag = mac(KEY, NONCE, AD, CT);
        run_txn("dec_vec", 1'b1, KEY, NONCE, AD, CT, good_tag, 0, 0, 0);
        run_txn("dec_badtag", 1'b1, KEY, NONCE, AD, CT, good_tag ^ 128'd1, 0, 0, 0);
    endtask

    task automatic test_sw8();
        logic [127:0] k, n, t, got_tag, exp_tag;
        logic [79:0]  d, got_res;
        logic [39:0]  a;
        logic         zero_tail;
        k = KEY;
        n = NONCE;
        a = AD;
        d = CT ^ keystream(KEY, NONCE, AD);
        t = rand128();
        exp_tag = mac(KEY, NONCE, AD, CT);
        for (int b = 0; b < 16; b++) begin
            @(negedge clk);
            in_valid8 = 1'b1;
            key8   = k[127:120];
            nonce8 = n[127:120];
            tag8   = t[127:120];
            ad8    = (b < 5) ? a[39:32] : 8'($urandom);
            data8  = (b < 10) ? d[79:72] : 8'($urandom);
            start8 = 1'($urandom);
            k = k << 8; n = n << 8; t = t << 8; a = a << 8; d = d << 8;
        end
        @(negedge clk);
        in_valid8 = 1'b0;
        start8    = 1'b0;
        n_tests++;
        if (in_ready8 !== 1'b0 || busy8 !== 1'b0
            || {core_key8, core_nonce8, core_ad8, core_data8} !== {KEY, NONCE, AD, CT ^ keystream(KEY, NONCE, AD)}) begin
            n_fail++;
            $display("FAIL sw8_core_fields: in_ready=%b busy=%b key=%h nonce=%h ad=%h data=%h",
                     in_ready8, busy8, core_key8, core_nonce8, core_ad8, core_data8);
        end
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n_tests++;
        if (core_start8 !== 1'b1 || busy8 !== 1'b1 || core_decrypt8 !== 1'b0) begin
            n_fail++;
            $display("FAIL sw8_launch: core_start=%b busy=%b core_decrypt=%b want 1 1 0",
                     core_start8, busy8, core_decrypt8);
        end
        @(negedge clk);
        core_result8 = core_data8 ^ keystream(core_key8, core_nonce8, core_ad8);
        core_tag8    = mac(core_key8, core_nonce8, core_ad8, core_result8);
        core_done8   = 1'b1;
        @(negedge clk);
        core_done8 = 1'b0;
        n_tests++;
        if (tag_ok_valid8 !== 1'b1 || tag_ok8 !== 1'b0 || core_start8 !== 1'b0) begin
            n_fail++;
            $display("FAIL sw8_tag_ok: tag_ok_valid=%b tag_ok=%b core_start=%b want 1 0 0",
                     tag_ok_valid8, tag_ok8, core_start8);
        end
        @(negedge clk);
        got_res = '0;
        got_tag = '0;
        zero_tail = 1'b1;
        for (int b = 0; b < 16; b++) begin
            if (out_valid8 !== 1'b1) zero_tail = 1'b0;
            if (b < 10) got_res = {got_res[71:0], data_so8};
            else if (data_so8 !== 8'h00) zero_tail = 1'b0;
            got_tag = {got_tag[119:0], tag_so8};
            out_ready8 = 1'b1;
            @(negedge clk);
        end
        out_ready8 = 1'b0;
        n_tests++;
        if (got_res !== CT || !zero_tail) begin
            n_fail++;
            $display("FAIL sw8_result: got %h valid_and_zero_tail=%b want %h", got_res, zero_tail, CT);
        end
        n_tests++;
        if (got_tag !== exp_tag || done8 !== 1'b1 || busy8 !== 1'b0 || in_ready8 !== 1'b1) begin
            n_fail++;
            $display("FAIL sw8_tag: got %h done=%b busy=%b in_ready=%b want %h 1 0 1",
                     got_tag, done8, busy8, in_ready8, exp_tag);
        end
    endtask

    task automatic test_throttle();
        logic [127:0] k, n, t;
        logic [39:0]  a;
        logic [79:0]  d;
        for (int j = 0; j < 3; j++) begin
            k = rand128();
            n = rand128();
            a = 40'(rand128());
            d = 80'(rand128());
            t = (j == 1) ? mac(k, n, a, d) : rand128();
            run_txn($sformatf("throttle%0d", j), 1'(j % 2), k, n, a, d, t, 1, 0, 0);
        end
        run_txn("throttle_vec", 1'b0, KEY, NONCE, AD, CT ^ keystream(KEY, NONCE, AD), rand128(), 1, 0, 0);
    endtask

    task automatic test_reset_abort();
        run_txn("abort_a", 1'b0, rand128(), rand128(), 40'(rand128()), 80'(rand128()), rand128(), 0, 0, 1);
        run_txn("abort_b", 1'b1, rand128(), rand128(), 40'(rand128()), 80'(rand128()), rand128(), 1, 0, 2);
        run_txn("after_abort", 1'b1, KEY, NONCE, AD, CT, mac(KEY, NONCE, AD, CT), 0, 0, 0);
    endtask

    task automatic test_early_done();
        run_txn("early_done", 1'b0, rand128(), rand128(), 40'(rand128()), 80'(rand128()), rand128(), 0, 1, 0);
    endtask

    task automatic test_back_to_back();
        logic [127:0] k, n;
        logic [39:0]  a;
        logic [79:0]  d;
        k = rand128();
        n = rand128();
        a = 40'(rand128());
        d = 80'(rand128());
        run_txn("b2b_enc", 1'b0, k, n, a, d, rand128(), 0, 0, 0);
        run_txn("b2b_dec", 1'b1, k, n, a, d ^ keystream(k, n, a), mac(k, n, a, d ^ keystream(k, n, a)), 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_sw8();
        test_throttle();
        test_reset_abort();
        test_early_done();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
